// File: rtl/uart_bus_master.sv
// uart_bus_master: decodes W/R/B byte commands from the serial receiver and masters the
// 6502 bus while the CPU is held, returning acks and read data as a byte stream.
module uart_bus_master #(
   parameter logic [19:0] TIMEOUT = 20'd500000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_bus_req,
   input  logic        i_bus_gnt,
   output logic [15:0] o_bus_addr,
   output logic [7:0]  o_bus_dout,
   output logic        o_bus_we,
   input  logic [7:0]  i_bus_din,
   output logic        o_busy,
   output logic        o_err
);
   typedef enum logic [2:0] {
      S_IDLE, S_GET_AH, S_GET_AL, S_GET_ARG, S_REQ, S_ACCESS, S_CAPTURE, S_RESP
   } state_t;
   state_t      r_state, w_next;
   logic [7:0]  r_op, r_arg, r_tx_data;
   logic [15:0] r_addr;
   logic [8:0]  r_cnt;
   logic [19:0] r_tmo;
   logic        r_err;
   logic        w_get, w_known, w_is_w, w_is_r, w_is_b, w_more, w_tmo_hit, w_err;
   assign w_get     = (r_state == S_GET_AH) || (r_state == S_GET_AL) || (r_state == S_GET_ARG);
   assign w_known   = (i_rx_data == 8'h57) || (i_rx_data == 8'h52) || (i_rx_data == 8'h42);
   assign w_is_w    = r_op == 8'h57;
   assign w_is_r    = r_op == 8'h52;
   assign w_is_b    = r_op == 8'h42;
   assign w_more    = w_is_b && (r_cnt > 9'd1);
   assign w_tmo_hit = (TIMEOUT != 20'd0) && w_get && !i_rx_valid && (r_tmo == TIMEOUT - 20'd1);
   assign w_err     = (i_rx_valid && ((r_state == S_IDLE) ? !w_known : !w_get)) || w_tmo_hit;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    w_next = i_rx_valid ? (w_known ? S_GET_AH : S_RESP) : r_state;
         S_GET_AH:  w_next = i_rx_valid ? S_GET_AL : r_state;
         S_GET_AL:  w_next = i_rx_valid ? (w_is_r ? S_REQ : S_GET_ARG) : r_state;
         S_GET_ARG: w_next = i_rx_valid ? S_REQ : r_state;
         S_REQ:     w_next = i_bus_gnt ? S_ACCESS : r_state;
         S_ACCESS:  w_next = !i_bus_gnt ? S_REQ : (w_is_w ? S_RESP : S_CAPTURE);
         S_CAPTURE: w_next = S_RESP;
         S_RESP:    w_next = i_tx_ready ? (w_more ? S_ACCESS : S_IDLE) : r_state;
         default:   w_next = S_IDLE;
      endcase
      if (w_tmo_hit) w_next = S_IDLE;
   end
   // Bus-facing strobes decode straight from state so reset drops them asynchronously
   assign o_bus_we   = (r_state == S_ACCESS) && i_bus_gnt && w_is_w;
   assign o_bus_req  = (r_state == S_REQ) || (r_state == S_ACCESS) || (r_state == S_CAPTURE) ||
                       ((r_state == S_RESP) && w_more);
   assign o_bus_addr = r_addr;
   assign o_bus_dout = o_bus_we ? r_arg : 8'h00;
   assign o_tx_valid = r_state == S_RESP;
   assign o_tx_data  = r_tx_data;
   assign o_busy     = r_state != S_IDLE;
   assign o_err      = r_err;
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_op      <= 8'h00;
         r_arg     <= 8'h00;
         r_addr    <= 16'h0000;
         r_cnt     <= 9'd0;
         r_tmo     <= 20'd0;
         r_tx_data <= 8'h00;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= w_err;
         r_tmo   <= (w_get && !i_rx_valid) ? r_tmo + 20'd1 : 20'd0;
         if (r_state == S_IDLE && i_rx_valid) begin
            r_op      <= i_rx_data;
            r_tx_data <= 8'h3F;
         end
         if (r_state == S_GET_AH && i_rx_valid) r_addr[15:8] <= i_rx_data;
         if (r_state == S_GET_AL && i_rx_valid) r_addr[7:0] <= i_rx_data;
         // N=0 encodes a 256-byte block
         if (r_state == S_GET_ARG && i_rx_valid) begin
            r_arg <= i_rx_data;
            r_cnt <= {i_rx_data == 8'h00, i_rx_data};
         end
         if (o_bus_we) r_tx_data <= 8'h4B;
         if (r_state == S_CAPTURE) r_tx_data <= i_bus_din;
         if (r_state == S_RESP && i_tx_ready && w_more) begin
            r_cnt  <= r_cnt - 9'd1;
            r_addr <= r_addr + 16'd1;
         end
      end
   end
endmodule
